// File: rtl/maze_cmd_seq.sv
// Maze-runner command sequencer: consumes turn codes, gates PID drive, supplies open-loop veer error.
// Optional buzzer tone and timed bump abort are built when MAZE_BUZZ_EN is defined.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | waiting for a command byte, drive off
// FOLLOW | PID line following, waiting for a line-loss event
// VEER   | open-loop turn in progress, minimum duration enforced by veer timer
// STOP   | sequence done, one-cycle response then IDLE
// BUMP   | collision abort, drive off, alarm tone while buzz timer runs
module maze_cmd_seq #(
    parameter bit          FAST_SIM = 1'b1,
    parameter logic [15:0] VEER_MAG = 16'h0400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    input  logic        line_present,
    input  logic        BMPL_n,
    input  logic        BMPR_n,
    output logic        go,
    output logic [15:0] err_opn_lp,
    output logic        send_resp,
    output logic        buzz
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FOLLOW = 3'd1;
    localparam logic [2:0] VEER   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
    localparam logic [2:0] BUMP   = 3'd4;

    localparam logic [22:0] VEER_MAX = FAST_SIM ? 23'd4096 : 23'd4194304;

    logic [2:0]  state;
    logic [7:0]  sreg;
    logic [22:0] veer_tmr;
    logic        bmpl_s1, bmpl_s2, bmpr_s1, bmpr_s2;
    logic        line_q;
    logic        bmp;
    logic        line_fall;
    logic        bump_done;

    assign bmp         = ~bmpl_s2 | ~bmpr_s2;
    assign line_fall   = line_q & ~line_present;
    assign go          = (state == FOLLOW) || (state == VEER);
    // Holding off the ack while send_resp is out keeps the two pulses disjoint.
    assign clr_cmd_rdy = (state == IDLE) && cmd_rdy && !send_resp;

    function automatic logic [15:0] turn_err(input logic [1:0] code);
        case (code)
            2'b01:   turn_err = -VEER_MAG;
            2'b10:   turn_err = VEER_MAG;
            default: turn_err = 16'h0000;
        endcase
    endfunction

`ifdef MAZE_BUZZ_EN
    localparam logic [25:0] BUZZ_MAX = FAST_SIM ? 26'd65535 : 26'd49999999;

    logic [14:0] buzz_cnt;
    logic [25:0] buzz_tmr;

    always_ff @(posedge clk) begin
        if (rst) begin
            buzz_cnt <= '0;
            buzz_tmr <= '0;
        end else begin
            buzz_cnt <= buzz_cnt + 15'd1;
            if (state == BUMP)
                buzz_tmr <= buzz_tmr + 26'd1;
            else
                buzz_tmr <= '0;
        end
    end

    assign bump_done = (buzz_tmr == BUZZ_MAX);
    assign buzz      = (state == BUMP) && buzz_cnt[14];
`else
    assign bump_done = 1'b1;
    assign buzz      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sreg       <= 8'hFF;
            err_opn_lp <= '0;
            send_resp  <= 1'b0;
            veer_tmr   <= '0;
            bmpl_s1    <= 1'b1;
            bmpl_s2    <= 1'b1;
            bmpr_s1    <= 1'b1;
            bmpr_s2    <= 1'b1;
            line_q     <= 1'b0;
        end else begin
            bmpl_s1   <= BMPL_n;
            bmpl_s2   <= bmpl_s1;
            bmpr_s1   <= BMPR_n;
            bmpr_s2   <= bmpr_s1;
            line_q    <= line_present;
            send_resp <= 1'b0;
            case (state)
                IDLE: begin
                    err_opn_lp <= '0;
                    if (cmd_rdy && !send_resp) begin
                        sreg  <= cmd;
                        state <= (cmd[1:0] == 2'b11) ? STOP : FOLLOW;
                    end
                end
                FOLLOW: begin
                    if (bmp) begin
                        sreg       <= 8'hFF;
                        err_opn_lp <= '0;
                        state      <= BUMP;
                    end else if (line_fall) begin
                        if (sreg[1:0] == 2'b11) begin
                            state <= STOP;
                        end else begin
                            err_opn_lp <= turn_err(sreg[1:0]);
                            sreg       <= {2'b11, sreg[7:2]};
                            veer_tmr   <= '0;
                            state      <= VEER;
                        end
                    end
                end
                VEER: begin
                    if (bmp) begin
                        sreg       <= 8'hFF;
                        err_opn_lp <= '0;
                        state      <= BUMP;
                    end else if (veer_tmr != VEER_MAX) begin
                        veer_tmr <= veer_tmr + 23'd1;
                    end else if (line_present) begin
                        err_opn_lp <= '0;
                        state      <= FOLLOW;
                    end
                end
                STOP: begin
                    err_opn_lp <= '0;
                    send_resp  <= 1'b1;
                    state      <= IDLE;
                end
                BUMP: begin
                    err_opn_lp <= '0;
`ifdef MAZE_BUZZ_EN
                    if (bump_done) begin
                        send_resp <= 1'b1;
                        state     <= IDLE;
                    end
`else
                    // Without the alarm the abort is a single cycle handed to STOP.
                    if (bump_done)
                        state <= STOP;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_cmd_seq.sv
// Randomized self-checking bench for maze_cmd_seq against a turn-queue reference model.
// Honors MAZE_BUZZ_EN for the bump/alarm expectations.
`timescale 1ns/1ps

module tb_maze_cmd_seq;

    localparam int          VEER_CYC = 4096;
    localparam logic [15:0] VMAG     = 16'h0400;
`ifdef MAZE_BUZZ_EN
    localparam int BUMP_LEN = 65536;
    localparam int N_RAND   = 0;
`else
    localparam int BUMP_LEN = 2;
    localparam int N_RAND   = 3;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        line_present;
    logic        BMPL_n;
    logic        BMPR_n;
    logic        go;
    logic [15:0] err_opn_lp;
    logic        send_resp;
    logic        buzz;

    int n_chk  = 0;
    int n_fail = 0;
    int n_resp = 0;

    maze_cmd_seq dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
        .cmd_rdy      (cmd_rdy),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .line_present (line_present),
        .BMPL_n       (BMPL_n),
        .BMPR_n       (BMPR_n),
        .go           (go),
        .err_opn_lp   (err_opn_lp),
        .send_resp    (send_resp),
        .buzz         (buzz)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference rule: open-loop error for a turn code.
    function automatic logic [15:0] turn_err(input logic [1:0] code);
        if (code == 2'b01) return 16'(-int'(VMAG));
        if (code == 2'b10) return VMAG;
        return 16'h0000;
    endfunction

    always @(negedge clk) begin
        chk("ack_resp_exclusive", 32'(clr_cmd_rdy & send_resp), 32'd0);
        if (send_resp) n_resp++;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        bit found = 0;
        cmd     = c;
        cmd_rdy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (clr_cmd_rdy) begin
                found = 1;
                break;
            end
        end
        chk("ack_seen", 32'(found), 32'd1);
        step();
        cmd_rdy = 1'b0;
        chk("go_after_cmd", 32'(go), 32'(c[1:0] != 2'b11));
    endtask

    task automatic do_veer(input logic [1:0] code, input int d);
        int exit_n = ((d > VEER_CYC) ? d : VEER_CYC) + 1;
        logic [15:0] want = turn_err(code);
        line_present = 1'b0;
        step();
        chk("veer_entry_err", 32'(err_opn_lp), 32'(want));
        chk("veer_go", 32'(go), 32'd1);
        if (d == 0) line_present = 1'b1;
        for (int n = 1; n <= exit_n; n++) begin
            step();
            if (n == d) line_present = 1'b1;
            if (n == exit_n - 1) chk("veer_hold_err", 32'(err_opn_lp), 32'(want));
            if (n == exit_n) begin
                chk("veer_exit_err", 32'(err_opn_lp), 32'd0);
                chk("veer_exit_go", 32'(go), 32'd1);
            end
        end
        step();
    endtask

    task automatic do_stop_fall();
        int r0;
        line_present = 1'b0;
        step();
        r0 = n_resp;
        chk("stop_go", 32'(go), 32'd0);
        chk("stop_err", 32'(err_opn_lp), 32'd0);
        step();
        chk("stop_resp", 32'(send_resp), 32'd1);
        step();
        chk("stop_resp_once", 32'(n_resp - r0), 32'd1);
        line_present = 1'b1;
        step();
        step();
    endtask

    task automatic stop_first();
        chk("stopcmd_resp_early", 32'(send_resp), 32'd0);
        chk("stopcmd_go", 32'(go), 32'd0);
        step();
        chk("stopcmd_resp", 32'(send_resp), 32'd1);
        chk("stopcmd_go2", 32'(go), 32'd0);
        step();
    endtask

    // Model: the byte is a queue of four turn codes followed by stop codes.
    task automatic run_cmd(input logic [7:0] c, input int d_first);
        logic [1:0] q[$];
        logic [1:0] code;
        for (int i = 0; i < 4; i++) q.push_back(c[2*i +: 2]);
        q.push_back(2'b11);
        send_cmd(c);
        if (c[1:0] == 2'b11) begin
            stop_first();
            return;
        end
        for (int i = 0; i < 5; i++) begin
            code = q.pop_front();
            if (code == 2'b11) begin
                do_stop_fall();
                return;
            end
            do_veer(code, (i == 0 && d_first >= 0) ? d_first : int'($urandom_range(0, 4300)));
        end
    endtask

    task automatic bump_test(input bit right, input bit with_fall, input bit hold_cmd);
        int resp_at = -1;
        int buzz_hi = 0;
        int go_hi = 0;
        bit early = 0;
        bit acked = 0;
        int r0;
        send_cmd(8'b00_00_10_01);
        if (right) BMPR_n = 1'b0; else BMPL_n = 1'b0;
        step();
        step();
        chk("go_pre_bump", 32'(go), 32'd1);
        if (with_fall) line_present = 1'b0;
        step();
        chk("bump_go", 32'(go), 32'd0);
        chk("bump_err", 32'(err_opn_lp), 32'd0);
        BMPL_n = 1'b1;
        BMPR_n = 1'b1;
        line_present = 1'b1;
        if (hold_cmd) begin
            cmd     = 8'h03;
            cmd_rdy = 1'b1;
        end
        for (int i = 0; i < BUMP_LEN + 20; i++) begin
            @(negedge clk);
            if (clr_cmd_rdy) early = 1;
            if (send_resp) begin
                resp_at = i;
                break;
            end
            if (buzz) buzz_hi++;
            if (go) go_hi++;
            chk("bump_err_hold", 32'(err_opn_lp), 32'd0);
        end
`ifdef MAZE_BUZZ_EN
        chk("bump_len", 32'(resp_at), 32'(BUMP_LEN));
        chk("buzz_duty", 32'(buzz_hi), 32'(BUMP_LEN / 2));
`else
        chk("bump_len", 32'(resp_at >= 1 && resp_at <= BUMP_LEN), 32'd1);
        chk("buzz_off", 32'(buzz_hi), 32'd0);
`endif
        chk("bump_go_low", 32'(go_hi), 32'd0);
        if (hold_cmd) begin
            chk("ack_during_bump", 32'(early), 32'd0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (clr_cmd_rdy) begin
                    acked = 1;
                    break;
                end
            end
            chk("ack_after_bump", 32'(acked), 32'd1);
            step();
            cmd_rdy = 1'b0;
            r0 = n_resp;
            for (int i = 0; i < 4; i++) step();
            chk("held_cmd_stop", 32'(n_resp - r0), 32'd1);
        end else begin
            step();
        end
        chk("bump_idle_go", 32'(go), 32'd0);
    endtask

    initial begin
        int r0;
        rst = 1'b1;
        cmd = 8'h00;
        cmd_rdy = 1'b0;
        line_present = 1'b1;
        BMPL_n = 1'b1;
        BMPR_n = 1'b1;
        step();
        step();
        chk("rst_go", 32'(go), 32'd0);
        chk("rst_err", 32'(err_opn_lp), 32'd0);
        chk("rst_resp", 32'(send_resp), 32'd0);
        chk("rst_ack", 32'(clr_cmd_rdy), 32'd0);
        chk("rst_buzz", 32'(buzz), 32'd0);
        rst = 1'b0;
        step();
        step();

        // bumps while idle are ignored
        r0 = n_resp;
        BMPL_n = 1'b0;
        for (int i = 0; i < 6; i++) step();
        BMPL_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("idle_bump_resp", 32'(n_resp - r0), 32'd0);
        chk("idle_bump_go", 32'(go), 32'd0);

        run_cmd(8'b11_00_10_01, 100);
        run_cmd(8'h03, -1);

        // reset while veering
        send_cmd(8'b11_11_11_10);
        line_present = 1'b0;
        step();
        for (int i = 0; i < 50; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_go", 32'(go), 32'd0);
        chk("midrst_err", 32'(err_opn_lp), 32'd0);
        chk("midrst_resp", 32'(send_resp), 32'd0);
        line_present = 1'b1;
        step();
        step();
        run_cmd(8'h03, -1);

`ifndef MAZE_BUZZ_EN
        bump_test(1'b0, 1'b0, 1'b0);
`endif
        bump_test(1'b1, 1'b1, 1'b1);

        for (int k = 0; k < N_RAND; k++) begin
            run_cmd(8'($urandom), -1);
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
